// File: rtl/instruction_register_if.sv
// instruction_register_if: TAP-controller-to-IR strobes, serial data and decoder-facing outputs.
interface instruction_register_if #(parameter int IR_WIDTH = 4);
   logic                tlr;
   logic                capture_ir;
   logic                shift_ir;
   logic                update_ir;
   logic                tdi;
   logic                tdo;
   logic                tdo_en;
   logic [IR_WIDTH-1:0] parallel_out;
   logic                ir_updated;
   modport master (
      output tlr, capture_ir, shift_ir, update_ir, tdi,
      input  tdo, tdo_en, parallel_out, ir_updated
   );
   modport slave (
      input  tlr, capture_ir, shift_ir, update_ir, tdi,
      output tdo, tdo_en, parallel_out, ir_updated
   );
endinterface

// File: rtl/instruction_register.sv
// instruction_register: JTAG IR shift stage plus update/hold stage feeding the instruction decoder.
// Optional IR_OPCODE_FILTER_EN replaces unknown opcodes with BYPASS at Update-IR.
module instruction_register #(
   parameter int                  IR_WIDTH      = 4,
   parameter logic [IR_WIDTH-1:0] CAPTURE_VALUE = IR_WIDTH'(4'b0001),
   parameter logic [IR_WIDTH-1:0] RESET_OPCODE  = IR_WIDTH'(4'b1110)
) (
   input logic                    TCK,
   input logic                    TRST,
   instruction_register_if.slave  ir
);
   logic [IR_WIDTH-1:0] shift_reg;
   logic [IR_WIDTH-1:0] parallel_out;
   logic [IR_WIDTH-1:0] commit;
   logic                tdo_en;
   logic                ir_updated;
`ifdef IR_OPCODE_FILTER_EN
   localparam logic [IR_WIDTH-1:0] EXTEST  = IR_WIDTH'(4'b0000);
   localparam logic [IR_WIDTH-1:0] SAMPLE  = IR_WIDTH'(4'b0001);
   localparam logic [IR_WIDTH-1:0] PRELOAD = IR_WIDTH'(4'b0010);
   localparam logic [IR_WIDTH-1:0] AHB     = IR_WIDTH'(4'b1010);
   localparam logic [IR_WIDTH-1:0] IDCODE  = IR_WIDTH'(4'b1110);
   localparam logic [IR_WIDTH-1:0] BYPASS  = '1;
   assign commit = (shift_reg inside {BYPASS, SAMPLE, PRELOAD, EXTEST, IDCODE, AHB}) ? shift_reg : BYPASS;
`else
   assign commit = shift_reg;
`endif
   always_ff @(posedge TCK or posedge TRST)
      if (TRST) begin
         shift_reg    <= CAPTURE_VALUE;
         parallel_out <= RESET_OPCODE;
         tdo_en       <= 1'b0;
         ir_updated   <= 1'b0;
      end else begin
         shift_reg    <= (ir.tlr || ir.capture_ir) ? CAPTURE_VALUE :
                         ir.shift_ir ? {ir.tdi, shift_reg[IR_WIDTH-1:1]} : shift_reg;
         // update samples the pre-edge shift_reg, so it coexists with capture/shift
         parallel_out <= ir.tlr ? RESET_OPCODE : ir.update_ir ? commit : parallel_out;
         ir_updated   <= !ir.tlr && ir.update_ir;
         tdo_en       <= ir.shift_ir;
      end
   assign ir.tdo          = shift_reg[0];
   assign ir.tdo_en       = tdo_en;
   assign ir.parallel_out = parallel_out;
   assign ir.ir_updated   = ir_updated;
endmodule
